// File: rtl/lsq_param.sv
// Load-store queue: in-order allocation by ROB tag, out-of-order loads with store-to-load
// forwarding, and stores written to memory only after commit through a single request port.
module lsq_param #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dis_valid,
  output logic                   dis_ready,
  input  logic                   dis_is_store,
  input  logic [TAG_W-1:0]       dis_tag,
  input  logic                   agu_valid,
  input  logic [TAG_W-1:0]       agu_tag,
  input  logic [XLEN-1:0]        agu_addr,
  input  logic [XLEN-1:0]        agu_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_wdata,
  output logic [TAG_W-1:0]       mem_req_tag,
  input  logic                   mem_resp_valid,
  input  logic [TAG_W-1:0]       mem_resp_tag,
  input  logic [XLEN-1:0]        mem_resp_data,
  output logic                   ld_done_valid,
  output logic [TAG_W-1:0]       ld_done_tag,
  output logic [XLEN-1:0]        ld_done_data,
  output logic                   ld_done_fwd,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]    head_q, tail_q, occ, head_nxt;
  logic [DEPTH-1:0] v_q, st_q, ar_q, iss_q, dn_q, cm_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic [IW-1:0] head_idx, tail_idx;
  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  assign occ       = tail_q - head_q;
  assign count     = occ;
  assign full      = (occ == PW'(DEPTH));
  assign empty     = (occ == '0);
  assign dis_ready = !full && !rst;

  logic head_v, head_st, head_cm;
  logic commit_fire, st_cm, ld_free, st_done, req_free, head_issue_st, issue_ld, keep, dis_fire;

  assign head_v       = v_q[head_idx];
  assign head_st      = st_q[head_idx];
  assign head_cm      = cm_q[head_idx];
  assign commit_ready = head_v && !head_cm && (head_st ? ar_q[head_idx] : dn_q[head_idx]);
  assign commit_fire  = commit_valid && commit_ready;
  assign st_cm        = commit_fire && head_st;
  assign ld_free      = commit_fire && !head_st;
  assign st_done      = mem_req_valid && mem_req_ready && mem_req_we;
  assign req_free     = !mem_req_valid || mem_req_ready;
  assign dis_fire     = dis_valid && dis_ready && !flush;
  assign head_nxt     = (st_done || ld_free) ? head_q + PW'(1) : head_q;
  // A retired store survives a flush until it has been written.
  assign keep         = head_v && head_st && (head_cm || st_cm) && !st_done;
  assign head_issue_st = head_v && head_st && head_cm && !iss_q[head_idx];

  // Load selection, forwarding source and response match.
  logic          sel_found, st_pending, fwd_hit, resp_hit;
  logic [IW-1:0] sel_idx, sel_age, scan_idx, resp_idx;
  logic [XLEN-1:0] fwd_data;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    st_pending = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + IW'(k);
      if (PW'(k) < occ && v_q[scan_idx] && !sel_found) begin
        if (st_q[scan_idx]) begin
          if (!ar_q[scan_idx]) st_pending = 1'b1;
        end else if (ar_q[scan_idx] && !iss_q[scan_idx] && !dn_q[scan_idx] && !st_pending) begin
          sel_found = 1'b1;
          sel_idx   = scan_idx;
          sel_age   = IW'(k);
        end
      end
    end

    // Scan oldest to youngest so the last hit is the youngest older store.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + IW'(k);
      if (sel_found && IW'(k) < sel_age && st_q[scan_idx] &&
          addr_q[scan_idx] == addr_q[sel_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end

    resp_hit = 1'b0;
    resp_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (mem_resp_valid && v_q[IW'(k)] && !st_q[IW'(k)] && iss_q[IW'(k)] && !dn_q[IW'(k)] &&
          tag_q[IW'(k)] == mem_resp_tag) begin
        resp_hit = 1'b1;
        resp_idx = IW'(k);
      end
    end
  end

  assign issue_ld = req_free && !head_issue_st && sel_found && !fwd_hit && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      v_q    <= '0;
      st_q   <= '0;
      ar_q   <= '0;
      iss_q  <= '0;
      dn_q   <= '0;
      cm_q   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_q[k]  <= '0;
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_tag   <= '0;
      ld_done_valid <= 1'b0;
      ld_done_tag   <= '0;
      ld_done_data  <= '0;
      ld_done_fwd   <= 1'b0;
    end else begin
      ld_done_valid <= 1'b0;

      if (dis_fire) begin
        v_q[tail_idx]   <= 1'b1;
        st_q[tail_idx]  <= dis_is_store;
        tag_q[tail_idx] <= dis_tag;
        ar_q[tail_idx]  <= 1'b0;
        iss_q[tail_idx] <= 1'b0;
        dn_q[tail_idx]  <= 1'b0;
        cm_q[tail_idx]  <= 1'b0;
        tail_q          <= tail_q + PW'(1);
      end

      if (agu_valid && !flush) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (v_q[IW'(k)] && tag_q[IW'(k)] == agu_tag) begin
            ar_q[IW'(k)]   <= 1'b1;
            addr_q[IW'(k)] <= agu_addr;
            if (st_q[IW'(k)]) data_q[IW'(k)] <= agu_data;
          end
        end
      end

      if (st_cm) cm_q[head_idx] <= 1'b1;

      // Memory responses win the completion slot; a blocked forward retries.
      if (!flush) begin
        if (resp_hit) begin
          dn_q[resp_idx] <= 1'b1;
          ld_done_valid  <= 1'b1;
          ld_done_tag    <= tag_q[resp_idx];
          ld_done_data   <= mem_resp_data;
          ld_done_fwd    <= 1'b0;
        end else if (sel_found && fwd_hit) begin
          iss_q[sel_idx] <= 1'b1;
          dn_q[sel_idx]  <= 1'b1;
          ld_done_valid  <= 1'b1;
          ld_done_tag    <= tag_q[sel_idx];
          ld_done_data   <= fwd_data;
          ld_done_fwd    <= 1'b1;
        end
      end

      if (mem_req_valid && !mem_req_ready) begin
        if (flush && !mem_req_we) mem_req_valid <= 1'b0;
      end else if (head_issue_st) begin
        mem_req_valid   <= 1'b1;
        mem_req_we      <= 1'b1;
        mem_req_addr    <= addr_q[head_idx];
        mem_req_wdata   <= data_q[head_idx];
        mem_req_tag     <= tag_q[head_idx];
        iss_q[head_idx] <= 1'b1;
      end else if (issue_ld) begin
        mem_req_valid  <= 1'b1;
        mem_req_we     <= 1'b0;
        mem_req_addr   <= addr_q[sel_idx];
        mem_req_wdata  <= '0;
        mem_req_tag    <= tag_q[sel_idx];
        iss_q[sel_idx] <= 1'b1;
      end else begin
        mem_req_valid <= 1'b0;
      end

      if (st_done || ld_free) v_q[head_idx] <= 1'b0;
      head_q <= head_nxt;

      if (flush) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!(keep && IW'(k) == head_idx)) v_q[IW'(k)] <= 1'b0;
        end
        tail_q <= keep ? head_q + PW'(1) : head_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lsq_param.sv
// Scoreboard bench for lsq_param: directed scenarios plus a randomized program checked
// against a program-order memory model; a negedge monitor pops and compares completions.
module tb_lsq_param;
  localparam int DEPTH = 16;
  localparam int N     = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dis_valid, dis_ready, dis_is_store;
  logic [5:0]  dis_tag;
  logic        agu_valid;
  logic [5:0]  agu_tag;
  logic [31:0] agu_addr, agu_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [5:0]  mem_req_tag;
  logic        mem_resp_valid;
  logic [5:0]  mem_resp_tag;
  logic [31:0] mem_resp_data;
  logic        ld_done_valid, ld_done_fwd;
  logic [5:0]  ld_done_tag;
  logic [31:0] ld_done_data;
  logic        commit_valid, commit_ready, flush;
  logic [4:0]  count;
  logic        full, empty;

  always #5 clk = ~clk;

  lsq_param #(.DEPTH(DEPTH), .XLEN(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_is_store(dis_is_store), .dis_tag(dis_tag),
    .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr), .agu_data(agu_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag), .ld_done_data(ld_done_data),
    .ld_done_fwd(ld_done_fwd), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  typedef struct {logic [5:0] tag; logic [31:0] data; int fwd;} exp_t;  // fwd 2 = either
  typedef struct {logic [5:0] tag; logic [31:0] data;} resp_t;

  exp_t        sb[$];
  resp_t       pend[$];
  logic [31:0] mem [logic [31:0]];
  int          rd_cnt [64];
  int          done_cnt [64];
  int          n_tests = 0;
  int          n_fail = 0;
  int          ready_mode = 1;  // 0 never, 1 random
  bit          hold_resp = 1'b0;

  bit          p_st [N];
  logic [5:0]  p_tag [N];
  logic [31:0] p_addr [N];
  logic [31:0] p_data [N];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Memory model: writes and read captures happen at the accepting edge.
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
      else begin
        pend.push_back('{tag: mem_req_tag, data: mem_rd(mem_req_addr)});
        rd_cnt[mem_req_tag]++;
      end
    end
  end

  initial begin
    int j;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_tag   = '0;
    mem_resp_data  = '0;
    forever begin
      step();
      mem_req_ready  = (ready_mode == 1) && ($urandom % 4 != 0);
      mem_resp_valid = 1'b0;
      if (!hold_resp && pend.size() > 0 && ($urandom % 2 == 0)) begin
        j = int'($urandom % pend.size());
        mem_resp_valid = 1'b1;
        mem_resp_tag   = pend[j].tag;
        mem_resp_data  = pend[j].data;
        pend.delete(j);
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    int idx;
    if (!rst && ld_done_valid) begin
      idx = -1;
      done_cnt[ld_done_tag]++;
      foreach (sb[i]) if (idx < 0 && sb[i].tag == ld_done_tag) idx = i;
      n_tests++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL ld_done_unexpected: tag %0d data %0h, required no completion",
                 ld_done_tag, ld_done_data);
      end else begin
        if (ld_done_data !== sb[idx].data) begin
          n_fail++;
          $display("FAIL ld_done_data tag %0d: got %0h, required %0h",
                   ld_done_tag, ld_done_data, sb[idx].data);
        end
        if (sb[idx].fwd != 2) begin
          n_tests++;
          if (ld_done_fwd !== (sb[idx].fwd == 1)) begin
            n_fail++;
            $display("FAIL ld_done_fwd tag %0d: got %0b, required %0d",
                     ld_done_tag, ld_done_fwd, sb[idx].fwd);
          end
        end
        sb.delete(idx);
      end
    end
  end

  task automatic dispatch(input bit st, input int tag);
    int guard;
    guard = 0;
    while (!dis_ready && guard < 1000) begin step(); guard++; end
    check("dispatch_ready", dis_ready, 1);
    dis_valid    = 1'b1;
    dis_is_store = st;
    dis_tag      = tag[5:0];
    step();
    dis_valid = 1'b0;
  endtask

  task automatic agu(input int tag, input logic [31:0] addr, input logic [31:0] data);
    agu_valid = 1'b1;
    agu_tag   = tag[5:0];
    agu_addr  = addr;
    agu_data  = data;
    step();
    agu_valid = 1'b0;
  endtask

  task automatic expect_ld(input int tag, input logic [31:0] data, input int fwd);
    sb.push_back('{tag: tag[5:0], data: data, fwd: fwd});
  endtask

  task automatic commit_n(input int n);
    int done, guard;
    done  = 0;
    guard = 0;
    while (done < n && guard < 2000) begin
      if (commit_ready) begin
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        done++;
      end else step();
      guard++;
    end
    check("commit_count", done, n);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(empty && sb.size() == 0) && guard < 3000) begin step(); guard++; end
    check("idle_empty", empty, 1);
    check("idle_scoreboard", sb.size(), 0);
  endtask

  function automatic exp_t model_load(input int i);
    exp_t e;
    e.tag  = p_tag[i];
    e.data = init_val(p_addr[i]);
    e.fwd  = 0;
    for (int k = 0; k < i; k++) begin
      if (p_st[k] && p_addr[k] == p_addr[i]) begin
        e.data = p_data[k];
        e.fwd  = 2;
      end
    end
    return e;
  endfunction

  initial begin
    int r0, d0, guard, disp, ncom, nd, j, o;
    dis_valid = 0; dis_is_store = 0; dis_tag = '0;
    agu_valid = 0; agu_tag = '0; agu_addr = '0; agu_data = '0;
    commit_valid = 0; flush = 0;
    rst = 1'b1;
    repeat (2) step();
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_ld_done_valid", ld_done_valid, 0);
    check("rst_commit_ready", commit_ready, 0);
    rst = 1'b0;
    step();
    check("dis_ready_after_rst", dis_ready, 1);

    // Fill and wrap.
    for (int t = 0; t < DEPTH; t++) dispatch(1'b0, t);
    check("fill_full", full, 1);
    check("fill_dis_ready", dis_ready, 0);
    check("fill_count", count, DEPTH);
    expect_ld(0, init_val(32'h1000), 0);
    agu(0, 32'h1000, 0);
    commit_n(1);
    check("after_commit_count", count, DEPTH - 1);
    dispatch(1'b0, 16);
    check("wrap_count", count, DEPTH);
    check("wrap_full", full, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_all_empty", empty, 1);
    check("flush_all_count", count, 0);

    // Store-to-load forwarding.
    r0 = rd_cnt[4];
    dispatch(1'b1, 3);
    dispatch(1'b0, 4);
    expect_ld(4, 32'hDEAD_BEEF, 1);
    agu(3, 32'h100, 32'hDEAD_BEEF);
    agu(4, 32'h100, 0);
    commit_n(2);
    wait_idle();
    check("fwd_no_read", rd_cnt[4], r0);
    check("fwd_store_written", mem_rd(32'h100), 32'hDEAD_BEEF);

    // Youngest older matching store wins.
    dispatch(1'b1, 10);
    dispatch(1'b1, 11);
    dispatch(1'b0, 12);
    expect_ld(12, 32'h22, 1);
    agu(10, 32'h40, 32'h11);
    agu(11, 32'h40, 32'h22);
    agu(12, 32'h40, 0);
    commit_n(3);
    wait_idle();
    check("youngest_mem_order", mem_rd(32'h40), 32'h22);

    // Older store without address blocks the load.
    r0 = rd_cnt[21];
    d0 = done_cnt[21];
    dispatch(1'b1, 20);
    dispatch(1'b0, 21);
    expect_ld(21, init_val(32'h300), 0);
    agu(21, 32'h300, 0);
    repeat (10) step();
    check("blocked_no_done", done_cnt[21], d0);
    check("blocked_no_read", rd_cnt[21], r0);
    agu(20, 32'h304, 32'h99);
    commit_n(2);
    wait_idle();
    check("unblocked_read", rd_cnt[21], r0 + 1);

    // Plain memory path.
    mem[32'h200] = 32'h55;
    r0 = rd_cnt[30];
    dispatch(1'b0, 30);
    expect_ld(30, 32'h55, 0);
    agu(30, 32'h200, 0);
    commit_n(1);
    wait_idle();
    check("mem_path_read", rd_cnt[30], r0 + 1);

    // Flush with a committed store at the head and a late response outstanding.
    r0 = rd_cnt[41];
    d0 = done_cnt[41];
    hold_resp = 1'b1;
    dispatch(1'b1, 40);
    dispatch(1'b0, 41);
    dispatch(1'b0, 42);
    agu(40, 32'h500, 32'hCAFE);
    agu(41, 32'h600, 0);
    guard = 0;
    while (rd_cnt[41] == r0 && guard < 500) begin step(); guard++; end
    check("flush_load_read_issued", rd_cnt[41], r0 + 1);
    ready_mode = 0;
    commit_n(1);
    repeat (2) step();
    check("flush_store_req_valid", mem_req_valid, 1);
    check("flush_store_req_we", mem_req_we, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_keeps_store", count, 1);
    check("flush_store_tag", mem_req_tag, 40);
    ready_mode = 1;
    wait_idle();
    check("flush_store_written", mem_rd(32'h500), 32'hCAFE);
    hold_resp = 1'b0;
    guard = 0;
    while (pend.size() > 0 && guard < 500) begin step(); guard++; end
    repeat (3) step();
    check("late_resp_sent", pend.size(), 0);
    check("late_resp_dropped", done_cnt[41], d0);
    check("late_resp_empty", empty, 1);

    // Randomized program against the program-order model.
    for (int i = 0; i < N; i++) begin
      p_st[i]   = ($urandom % 5) < 2;
      p_tag[i]  = 6'(i % 64);
      p_addr[i] = 32'h8000 + 32'(4 * ($urandom % 8));
      p_data[i] = $urandom;
    end
    begin
      int agu_q[$];
      disp  = 0;
      ncom  = 0;
      guard = 0;
      while (ncom < N && guard < 20000) begin
        nd = -1;
        dis_valid = 0; agu_valid = 0; commit_valid = 0;
        if (disp < N && dis_ready && ($urandom % 4 != 0)) begin
          if (!p_st[disp]) sb.push_back(model_load(disp));
          dis_valid    = 1'b1;
          dis_is_store = p_st[disp];
          dis_tag      = p_tag[disp];
          nd           = disp;
          disp++;
        end
        if (agu_q.size() > 0 && ($urandom % 3 != 0)) begin
          j = int'($urandom % agu_q.size());
          o = agu_q[j];
          agu_q.delete(j);
          agu_valid = 1'b1;
          agu_tag   = p_tag[o];
          agu_addr  = p_addr[o];
          agu_data  = p_data[o];
        end
        if (commit_ready && ($urandom % 2 == 0)) begin
          commit_valid = 1'b1;
          ncom++;
        end
        step();
        if (nd >= 0) agu_q.push_back(nd);
        guard++;
      end
    end
    dis_valid = 0; agu_valid = 0; commit_valid = 0;
    check("rand_all_committed", ncom, N);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
